// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants, FSM state encoding and phase-length helper for
// the binary neural network inference core (bnn_top).
package bnn_pkg;

  localparam int IMG_W    = 28;
  localparam int K        = 3;
  localparam int CONV_W   = IMG_W - K + 1;      // 26
  localparam int POOL_W   = CONV_W / 2;         // 13
  localparam int N_POOL   = POOL_W * POOL_W;    // 169 features per channel
  localparam int N_FEAT   = 2 * N_POOL;         // 338
  localparam int N_CLS    = 10;
  localparam int CONV_THR = 5;
  localparam int N_PIX    = IMG_W * IMG_W;      // 784
  localparam int SCORE_W  = 9;
  localparam int CNT_W    = 10;

  // Phase lengths in cycles. ARGMAX spans two cycles: result register, then done.
  localparam int LEN_IMG    = N_PIX;
  localparam int LEN_W      = K * K;
  localparam int LEN_WAIT   = 1;
  localparam int LEN_CONV   = N_POOL;
  localparam int LEN_FC     = N_FEAT;
  localparam int LEN_DRAIN  = 1;
  localparam int LEN_ARGMAX = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_IMG, S_W0, S_W1, S_WAIT, S_CONV, S_FC, S_DRAIN, S_ARGMAX
  } state_e;

  // Value of the phase counter in the final cycle of a state.
  function automatic logic [CNT_W-1:0] phase_last(input state_e s);
    case (s)
      S_IMG:    return CNT_W'(LEN_IMG - 1);
      S_W0:     return CNT_W'(LEN_W - 1);
      S_W1:     return CNT_W'(LEN_W - 1);
      S_WAIT:   return CNT_W'(LEN_WAIT - 1);
      S_CONV:   return CNT_W'(LEN_CONV - 1);
      S_FC:     return CNT_W'(LEN_FC - 1);
      S_DRAIN:  return CNT_W'(LEN_DRAIN - 1);
      S_ARGMAX: return CNT_W'(LEN_ARGMAX - 1);
      default:  return '0;
    endcase
  endfunction

endpackage

// File: rtl/bnn_conv_pool_unit.sv
// bnn_conv_pool_unit: combinational 3x3 XNOR-popcount conv over the four
// positions of a 2x2 pool window, followed by OR (binary max) pooling.
//   win_i    : 4x4 image window, [row][col]
//   kern_i   : 3x3 kernel, bit r*3+c = k[r][c]
//   pooled_o : pooled feature bit
module bnn_conv_pool_unit
  import bnn_pkg::*;
(
  input  logic [3:0][3:0] win_i,
  input  logic [K*K-1:0]  kern_i,
  output logic            pooled_o
);

  logic [3:0] conv;

  for (genvar dy = 0; dy < 2; dy++) begin : g_dy
    for (genvar dx = 0; dx < 2; dx++) begin : g_dx
      logic [K*K-1:0] match;
      for (genvar r = 0; r < K; r++) begin : g_r
        for (genvar c = 0; c < K; c++) begin : g_c
          assign match[r*K+c] = ~(win_i[dy+r][dx+c] ^ kern_i[r*K+c]);
        end
      end
      assign conv[dy*2+dx] = ($countones(match) >= CONV_THR);
    end
  end

  assign pooled_o = |conv;

endmodule

// File: rtl/bnn_top.sv
// bnn_top: BNN inference core for 28x28 binary digits.
// Streams image, two 3x3 kernels and ten FC weight streams, then runs
// conv+pool (one pooled position per cycle), FC popcount and argmax.
//   clk, rstn          : clock, synchronous active-low reset
//   start              : begin inference (IDLE only)
//   image_in           : pixel stream, row-major, one per IMG cycle
//   weight_conv_in     : kernel bit, one cycle after weight_en_0/1
//   weight_fc_*_in     : FC weight bits, one cycle after fc_ivalid
//   weight_en_0/1      : kernel-0/1 bit request
//   fc_ivalid          : FC weight request
//   done               : one-cycle result pulse
//   classes_b          : winning class
// Optional: define BNN_SCORE_OUT_EN to add score_max (winning popcount).
module bnn_top
  import bnn_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       start,
  input  logic       image_in,
  input  logic       weight_conv_in,
  input  logic       weight_fc_0_in,
  input  logic       weight_fc_1_in,
  input  logic       weight_fc_2_in,
  input  logic       weight_fc_3_in,
  input  logic       weight_fc_4_in,
  input  logic       weight_fc_5_in,
  input  logic       weight_fc_6_in,
  input  logic       weight_fc_7_in,
  input  logic       weight_fc_8_in,
  input  logic       weight_fc_9_in,
  output logic       weight_en_0,
  output logic       weight_en_1,
  output logic       fc_ivalid,
  output logic       done,
  output logic [3:0] classes_b
`ifdef BNN_SCORE_OUT_EN
  ,
  output logic [SCORE_W-1:0] score_max
`endif
);

  state_e                          state_q, state_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;
  logic [3:0]                      pr_q, pc_q;
  logic [N_PIX-1:0]                img_q;
  logic [1:0][K*K-1:0]             kern_q;
  logic [N_FEAT-1:0]               feat_q;
  logic                            cap_vld_q, cap_ch_q;
  logic [3:0]                      cap_bit_q;
  logic                            fc_vld_q, fbit_q;
  logic [N_CLS-1:0][SCORE_W-1:0]   score_q;
  logic [3:0]                      classes_q;
  logic [N_CLS-1:0]                wfc;
  logic [3:0][3:0]                 win;
  logic [1:0]                      pooled;
  logic [3:0]                      best_idx;
  logic [SCORE_W-1:0]              best_val;

  assign wfc = {weight_fc_9_in, weight_fc_8_in, weight_fc_7_in, weight_fc_6_in,
                weight_fc_5_in, weight_fc_4_in, weight_fc_3_in, weight_fc_2_in,
                weight_fc_1_in, weight_fc_0_in};

  // ---- FSM: state register ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    logic last;
    last    = (cnt_q == phase_last(state_q));
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_IMG;
      S_IMG:    if (last)  state_d = S_W0;
      S_W0:     if (last)  state_d = S_W1;
      S_W1:     if (last)  state_d = S_WAIT;
      S_WAIT:   if (last)  state_d = S_CONV;
      S_CONV:   if (last)  state_d = S_FC;
      S_FC:     if (last)  state_d = S_DRAIN;
      S_DRAIN:  if (last)  state_d = S_ARGMAX;
      S_ARGMAX: if (last)  state_d = S_IDLE;
      default:             state_d = S_IDLE;
    endcase
    // Phase counter restarts on every state change.
    cnt_d = (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + 1'b1;
  end

  // ---- FSM: outputs ----
  always_comb begin
    weight_en_0 = (state_q == S_W0);
    weight_en_1 = (state_q == S_W1);
    fc_ivalid   = (state_q == S_FC);
    done        = (state_q == S_ARGMAX) && (cnt_q == CNT_W'(1));
  end

  // ---- Control registers ----
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pr_q      <= '0;
      pc_q      <= '0;
      cap_vld_q <= 1'b0;
      cap_ch_q  <= 1'b0;
      cap_bit_q <= '0;
      fc_vld_q  <= 1'b0;
      score_q   <= '0;
      classes_q <= '0;
    end else begin
      // Pool position walks row-major over 13x13 during CONV.
      if (state_q == S_CONV) begin
        if (pc_q == 4'(POOL_W - 1)) begin
          pc_q <= '0;
          pr_q <= pr_q + 1'b1;
        end else begin
          pc_q <= pc_q + 1'b1;
        end
      end else begin
        pr_q <= '0;
        pc_q <= '0;
      end
      // Kernel responses arrive one cycle after the request.
      cap_vld_q <= (state_q == S_W0) || (state_q == S_W1);
      cap_ch_q  <= (state_q == S_W1);
      cap_bit_q <= cnt_q[3:0];
      fc_vld_q  <= (state_q == S_FC);
      if (state_q == S_IDLE && start) begin
        score_q <= '0;
      end else if (fc_vld_q) begin
        for (int j = 0; j < N_CLS; j++)
          score_q[j] <= score_q[j] + {{(SCORE_W-1){1'b0}}, ~(fbit_q ^ wfc[j])};
      end
      if (state_q == S_ARGMAX && cnt_q == '0) classes_q <= best_idx;
    end
  end

  // ---- Datapath storage (no reset needed; fully rewritten each run) ----
  always_ff @(posedge clk) begin
    if (state_q == S_IMG) img_q[cnt_q] <= image_in;
    if (cap_vld_q) kern_q[cap_ch_q][cap_bit_q] <= weight_conv_in;
    if (state_q == S_CONV) begin
      feat_q[cnt_q[8:0]]                <= pooled[0];
      feat_q[9'(N_POOL) + cnt_q[8:0]]   <= pooled[1];
    end
    // Feature bit is staged so it lines up with the weight response.
    fbit_q <= feat_q[cnt_q[8:0]];
  end

  // ---- 4x4 window at image (2*pr, 2*pc) ----
  for (genvar r = 0; r < 4; r++) begin : g_wr
    for (genvar c = 0; c < 4; c++) begin : g_wc
      logic [9:0] idx;
      assign idx       = 10'((2 * pr_q + r) * IMG_W + 2 * pc_q + c);
      assign win[r][c] = img_q[idx];
    end
  end

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    bnn_conv_pool_unit u_cpu (
      .win_i    (win),
      .kern_i   (kern_q[ch]),
      .pooled_o (pooled[ch])
    );
  end

  // ---- Argmax: strict > keeps the lowest index on ties ----
  always_comb begin
    best_idx = '0;
    best_val = score_q[0];
    for (int j = 1; j < N_CLS; j++) begin
      if (score_q[j] > best_val) begin
        best_val = score_q[j];
        best_idx = 4'(j);
      end
    end
  end

  assign classes_b = classes_q;

`ifdef BNN_SCORE_OUT_EN
  logic [SCORE_W-1:0] score_max_q;
  always_ff @(posedge clk) begin
    if (!rstn)                                    score_max_q <= '0;
    else if (state_q == S_ARGMAX && cnt_q == '0)  score_max_q <= best_val;
  end
  assign score_max = score_max_q;
`endif

endmodule

// File: tb/tb_bnn_top.sv
// tb_bnn_top: directed self-checking bench for bnn_top.
module tb_bnn_top;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       start = 1'b0;
  logic       image_in = 1'b0;
  logic       weight_conv_in = 1'b0;
  logic [9:0] wfc = '0;
  logic       weight_en_0, weight_en_1, fc_ivalid, done;
  logic [3:0] classes_b;
`ifdef BNN_SCORE_OUT_EN
  logic [8:0] score_max;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int mode = 0;
  int start_cyc = 0;

  bnn_top dut (
    .clk(clk), .rstn(rstn), .start(start), .image_in(image_in),
    .weight_conv_in(weight_conv_in),
    .weight_fc_0_in(wfc[0]), .weight_fc_1_in(wfc[1]), .weight_fc_2_in(wfc[2]),
    .weight_fc_3_in(wfc[3]), .weight_fc_4_in(wfc[4]), .weight_fc_5_in(wfc[5]),
    .weight_fc_6_in(wfc[6]), .weight_fc_7_in(wfc[7]), .weight_fc_8_in(wfc[8]),
    .weight_fc_9_in(wfc[9]),
    .weight_en_0(weight_en_0), .weight_en_1(weight_en_1), .fc_ivalid(fc_ivalid),
    .done(done), .classes_b(classes_b)
`ifdef BNN_SCORE_OUT_EN
    , .score_max(score_max)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Modes: 0 zero img / k=0 / class3 ones; 1 one img / k=0 / class7 zeros;
  // 2 zero img / identical FC streams; 3 threshold kernels; 4 half image.
  function automatic logic pix(input int m, input int i);
    case (m)
      1, 3:    return 1'b1;
      4:       return (i / 28) >= 14;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic kbit(input int m, input int idx);
    logic [17:0] kv;
    case (m)
      3:       kv = {9'h00F, 9'h01F};   // k0: 5 ones, k1: 4 ones
      4:       kv = {9'h1FF, 9'h000};
      default: kv = '0;
    endcase
    return kv[idx[4:0]];
  endfunction

  // Expected features for mode 4: ch0 = 1 for pr<=6, ch1 = 1 for pr>=6.
  function automatic logic ef(input int k);
    if (k < 169) return (k / 13) <= 6;
    return ((k - 169) / 13) >= 6;
  endfunction

  function automatic int flip_pos(input int j);
    case (j)
      0: return 78;  1: return 103; 2: return 237; 3: return 259; 4: return 0;
      5: return 168; 6: return 169; 7: return 337; default: return 91;
    endcase
  endfunction

  function automatic logic fcw(input int m, input int j, input int k);
    case (m)
      0:       return j == 3;
      1:       return j != 7;
      2:       return (k % 3) == 0;
      3:       return (j == 2) ? (k < 169) : (j == 0);
      4:       return (j == 9) ? ef(k) : (ef(k) ^ (k == flip_pos(j)));
      default: return 1'b0;
    endcase
  endfunction

  // ---- Serial source model + strobe statistics ----
  logic pend_k = 0, pend_f = 0, prev0 = 0, prev1 = 0, prevf = 0;
  int pend_kidx = 0, pend_fidx = 0;
  int n0 = 0, n1 = 0, nf = 0, f0 = 0, l0 = 0, f1 = 0, l1 = 0, ff = 0, lf = 0, ovl = 0;

  always @(negedge clk) begin
    weight_conv_in = pend_k ? kbit(mode, pend_kidx) : 1'b0;
    for (int j = 0; j < 10; j++) wfc[j] = pend_f ? fcw(mode, j, pend_fidx) : 1'b0;
    pend_k = weight_en_0 | weight_en_1;
    pend_f = fc_ivalid;
    if (weight_en_0) begin
      if (!prev0) begin n0 = 0; f0 = cyc; end
      pend_kidx = n0; n0++; l0 = cyc;
    end
    if (weight_en_1) begin
      if (!prev1) begin n1 = 0; f1 = cyc; end
      pend_kidx = 9 + n1; n1++; l1 = cyc;
    end
    if (fc_ivalid) begin
      if (!prevf) begin nf = 0; ff = cyc; end
      pend_fidx = nf; nf++; lf = cyc;
    end
    if (int'(weight_en_0) + int'(weight_en_1) + int'(fc_ivalid) > 1) ovl++;
    prev0 = weight_en_0; prev1 = weight_en_1; prevf = fc_ivalid;
  end

  // Call at a negedge with the DUT in IDLE. Returns done cycle offset or -1.
  task automatic do_run(input int m, input bit hold, output int done_at);
    mode = m; start = 1'b1; start_cyc = cyc; done_at = -1;
    for (int i = 0; i < 784; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      image_in = pix(m, i);
    end
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (done) begin done_at = cyc - start_cyc; break; end
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({weight_en_0, weight_en_1, fc_ivalid, done, classes_b} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {weight_en_0, weight_en_1, fc_ivalid, done, classes_b});
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int d;
    @(negedge clk);
    do_run(0, 1'b0, d);
    checks++;
    if (d !== 1313) begin failures++; $display("FAIL basic_done_cycle got=%0d exp=1313", d); end
    checks++;
    if (classes_b !== 4'd3) begin failures++; $display("FAIL basic_class got=%0d exp=3", classes_b); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", done); end
    checks++;
    if (f0 - start_cyc !== 785 || n0 !== 9 || l0 - f0 !== 8) begin
      failures++;
      $display("FAIL strobe_en0 got first=%0d n=%0d span=%0d exp 785 9 8", f0 - start_cyc, n0, l0 - f0);
    end
    checks++;
    if (f1 - start_cyc !== 794 || n1 !== 9 || l1 - f1 !== 8) begin
      failures++;
      $display("FAIL strobe_en1 got first=%0d n=%0d span=%0d exp 794 9 8", f1 - start_cyc, n1, l1 - f1);
    end
    checks++;
    if (ff - start_cyc !== 973 || nf !== 338 || lf - ff !== 337) begin
      failures++;
      $display("FAIL strobe_fc got first=%0d n=%0d span=%0d exp 973 338 337", ff - start_cyc, nf, lf - ff);
    end
    checks++;
    if (ovl !== 0) begin failures++; $display("FAIL strobe_overlap got=%0d exp=0", ovl); end
  endtask

  task automatic test_all_one;
    int d;
    @(negedge clk);
    do_run(1, 1'b0, d);
    checks++;
    if (d !== 1313 || classes_b !== 4'd7) begin
      failures++; $display("FAIL all_one got done=%0d class=%0d exp 1313 7", d, classes_b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (classes_b !== 4'd7) begin failures++; $display("FAIL result_hold got=%0d exp=7", classes_b); end
  endtask

  task automatic test_tie;
    int d;
    @(negedge clk);
    do_run(2, 1'b0, d);
    checks++;
    if (d !== 1313 || classes_b !== 4'd0) begin
      failures++; $display("FAIL tie_lowest got done=%0d class=%0d exp 1313 0", d, classes_b);
    end
  endtask

  task automatic test_threshold;
    int d;
    @(negedge clk);
    do_run(3, 1'b0, d);
    checks++;
    if (d !== 1313 || classes_b !== 4'd2) begin
      failures++; $display("FAIL conv_threshold got done=%0d class=%0d exp 1313 2", d, classes_b);
    end
  endtask

  task automatic test_window;
    int d;
    @(negedge clk);
    do_run(4, 1'b0, d);
    checks++;
    if (d !== 1313 || classes_b !== 4'd9) begin
      failures++; $display("FAIL conv_window got done=%0d class=%0d exp 1313 9", d, classes_b);
    end
  endtask

  task automatic test_reset_mid_fc;
    int d;
    int strobes;
    @(negedge clk);
    mode = 0; image_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < 1100 && !fc_ivalid; t++) @(negedge clk);
    checks++;
    if (fc_ivalid !== 1'b1) begin failures++; $display("FAIL reach_fc got=%b exp=1", fc_ivalid); end
    repeat (50) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if ({weight_en_0, weight_en_1, fc_ivalid, done, classes_b} !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_fc got=%b exp=00000000",
               {weight_en_0, weight_en_1, fc_ivalid, done, classes_b});
    end
    rstn = 1'b1;
    strobes = 0;
    repeat (900) begin
      @(negedge clk);
      if (weight_en_0 || weight_en_1 || fc_ivalid || done) strobes++;
    end
    checks++;
    if (strobes !== 0) begin failures++; $display("FAIL idle_after_reset got=%0d exp=0", strobes); end
    do_run(0, 1'b0, d);
    checks++;
    if (d !== 1313 || classes_b !== 4'd3) begin
      failures++; $display("FAIL rerun_after_reset got done=%0d class=%0d exp 1313 3", d, classes_b);
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, c1, c2;
    @(negedge clk);
    do_run(1, 1'b1, d1);
    c1 = cyc;
    checks++;
    if (d1 !== 1313 || classes_b !== 4'd7) begin
      failures++; $display("FAIL b2b_run1 got done=%0d class=%0d exp 1313 7", d1, classes_b);
    end
    @(negedge clk);
    do_run(0, 1'b0, d2);
    c2 = cyc;
    checks++;
    if (d2 !== 1313 || classes_b !== 4'd3) begin
      failures++; $display("FAIL b2b_run2 got done=%0d class=%0d exp 1313 3", d2, classes_b);
    end
    checks++;
    if (c2 - c1 !== 1314) begin failures++; $display("FAIL b2b_gap got=%0d exp=1314", c2 - c1); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_all_one;
    test_tie;
    test_threshold;
    test_window;
    test_reset_mid_fc;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
